// File: rtl/syscall_pkg.sv
// Shared syscall codes and UART transmitter state encoding for the FASVR syscall path.
package syscall_pkg;

    localparam logic [7:0] SYS_EXIT     = 8'h01;
    localparam logic [7:0] SYS_PUTCHAR  = 8'h03;
    localparam logic [7:0] SYS_PUTFLOAT = 8'h04;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: pops one byte when idle and shifts it out LSB first at DIV clocks per bit.
module uart_tx_serializer
    import syscall_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       txd,
    output logic       idle
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    uart_tx_state_t state_r, state_s;
    logic [CW-1:0]  baud_r, baud_s;
    logic [2:0]     bit_r, bit_s;
    logic [7:0]     shift_r, shift_s;
    logic           txd_r, txd_s;
    logic           baud_tick_s;

    assign baud_tick_s = (baud_r == DIV_LAST);
    assign byte_ready  = (state_r == IDLE);
    assign idle        = (state_r == IDLE);
    assign txd         = txd_r;

    // Next-state, baud/bit counting and line level; the line is registered so it lags state by a cycle.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        txd_s   = 1'b1;
        case (state_r)
            IDLE: begin
                txd_s  = 1'b1;
                baud_s = '0;
                bit_s  = 3'd0;
                if (byte_valid) begin
                    shift_s = byte_data;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                txd_s = 1'b0;
                if (baud_tick_s) begin
                    baud_s  = '0;
                    state_s = DATA;
                end else begin
                    baud_s = baud_r + CW'(1);
                end
            end
            DATA: begin
                txd_s = shift_r[0];
                if (baud_tick_s) begin
                    baud_s  = '0;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        bit_s   = 3'd0;
                        state_s = STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + CW'(1);
                end
            end
            STOP: begin
                txd_s = 1'b1;
                if (baud_tick_s) begin
                    baud_s  = '0;
                    state_s = IDLE;
                end else begin
                    baud_s = baud_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = '0;
                bit_s   = 3'd0;
                txd_s   = 1'b1;
            end
        endcase
    end

    // Transmitter state register; reset aborts any frame in flight and returns the line high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            txd_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            txd_r   <= txd_s;
        end
    end

endmodule

// File: rtl/syscall_uart_bridge.sv
// Syscall decode, tohost mirror and putchar FIFO feeding the UART serializer.
module syscall_uart_bridge
    import syscall_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_syscall_valid,
    output logic        io_syscall_ready,
    input  logic [7:0]  io_syscall_code,
    input  logic [31:0] io_syscall_arg,
    output logic [7:0]  io_tohost,
    output logic [31:0] io_tohost_arg,
    output logic        io_uart_txd,
    output logic        io_exited,
    output logic [31:0] io_exit_code
);

    localparam int DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);

    logic [7:0]  fifo_mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r, rd_ptr_r;
    logic        fifo_full_s, fifo_empty_s;
    logic        ready_s, fire_s, push_s, pop_s;
    logic        tx_ready_s, ser_idle_s, tx_idle_s;
    logic [7:0]  tohost_r;
    logic [31:0] tohost_arg_r, exit_code_r;
    logic        exited_r;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                          (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign tx_idle_s    = ser_idle_s & fifo_empty_s;
    assign fire_s       = io_syscall_valid & ready_s;
    assign push_s       = fire_s & (io_syscall_code == SYS_PUTCHAR);
    assign pop_s        = tx_ready_s & ~fifo_empty_s;

    assign io_syscall_ready = ready_s;
    assign io_tohost        = tohost_r;
    assign io_tohost_arg    = tohost_arg_r;
    assign io_exited        = exited_r;
    assign io_exit_code     = exit_code_r;

    // Acceptance depends only on the code and bridge state, never on this cycle's pop.
    always_comb begin
        ready_s = 1'b0;
        if (exited_r) begin
            ready_s = 1'b0;
        end else begin
            case (io_syscall_code)
                SYS_PUTCHAR: ready_s = ~fifo_full_s;
                SYS_EXIT:    ready_s = fifo_empty_s & tx_idle_s;
                default:     ready_s = 1'b1;
            endcase
        end
    end

    // Putchar byte FIFO; simultaneous push and pop both take effect.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r[AW-1:0]] <= io_syscall_arg[7:0];
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Mirror of accepted requests and sticky exit status.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tohost_r     <= 8'h00;
            tohost_arg_r <= 32'h0000_0000;
            exited_r     <= 1'b0;
            exit_code_r  <= 32'h0000_0000;
        end else begin
            tohost_r <= fire_s ? io_syscall_code : 8'h00;
            if (fire_s) begin
                tohost_arg_r <= io_syscall_arg;
            end
            if (fire_s && (io_syscall_code == SYS_EXIT)) begin
                exited_r    <= 1'b1;
                exit_code_r <= io_syscall_arg;
            end
        end
    end

    uart_tx_serializer #(
        .DIV (DIV)
    ) u_tx (
        .clock      (clock),
        .reset      (reset),
        .byte_data  (fifo_mem_r[rd_ptr_r[AW-1:0]]),
        .byte_valid (~fifo_empty_s),
        .byte_ready (tx_ready_s),
        .txd        (io_uart_txd),
        .idle       (ser_idle_s)
    );

endmodule

// File: tb/tb_syscall_uart_bridge.sv
// Directed bench for syscall_uart_bridge: byte scoreboard checked by a UART line decoder.
module tb_syscall_uart_bridge;
    import syscall_pkg::*;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = CLK_HZ / BAUD;   // 16 clocks per bit keeps the run short
    localparam int FRAME  = 10 * DIV;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  code  = 8'h00;
    logic [31:0] arg   = 32'h0;
    logic        ready;
    logic [7:0]  tohost;
    logic [31:0] tohost_arg;
    logic        txd;
    logic        exited;
    logic [31:0] exit_code;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fire_cyc = 0;
    logic [7:0] exp_q[$];
    int fall_q[$];

    syscall_uart_bridge #(
        .CLOCK_FREQ (CLK_HZ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .io_syscall_valid (valid),
        .io_syscall_ready (ready),
        .io_syscall_code  (code),
        .io_syscall_arg   (arg),
        .io_tohost        (tohost),
        .io_tohost_arg    (tohost_arg),
        .io_uart_txd      (txd),
        .io_exited        (exited),
        .io_exit_code     (exit_code)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request, wait (bounded) for ready, and check the mirror right after the fire edge.
    task automatic send(input logic [7:0] c, input logic [31:0] a, input int budget, output int waited);
        waited = 0;
        @(negedge clock);
        valid = 1'b1; code = c; arg = a;
        #1;
        while (!ready && waited < budget) begin
            @(negedge clock); #1;
            waited++;
        end
        check("ready_before_timeout", {31'b0, ready}, 32'h1);
        if (ready) begin
            @(posedge clock); #1;
            fire_cyc = cyc;
            valid = 1'b0;
            check("tohost_code", {24'h0, tohost}, {24'h0, c});
            check("tohost_arg", tohost_arg, a);
        end else begin
            valid = 1'b0;
        end
    endtask

    task automatic wait_falls(input int n, input int budget);
        int k;
        k = 0;
        while (fall_q.size() < n && k < budget) begin
            @(posedge clock); #1;
            k++;
        end
        check("frame_start_seen", fall_q.size(), n);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clock); #1;
            k++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (2 * DIV) @(posedge clock);
        #1;
    endtask

    task automatic count_lows(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            if (txd !== 1'b1) lows++;
        end
    endtask

    // Line decoder: finds start bits, samples mid-bit, drops frames cut by reset, scores the rest.
    initial begin : uart_mon
        logic       prev;
        logic       aborted;
        logic       stop_bit;
        logic [7:0] b;
        int         idx;
        prev = 1'b1;
        forever begin
            @(posedge clock); #1;
            if (reset && prev && !txd) begin
                fall_q.push_back(cyc);
                aborted = 1'b0; stop_bit = 1'b0; b = 8'h00;
                for (int k = 1; k <= 9 * DIV + DIV / 2; k++) begin
                    @(posedge clock); #1;
                    if (!reset) aborted = 1'b1;
                    if (k > DIV && (k % DIV) == DIV / 2) begin
                        idx = k / DIV - 1;
                        if (idx < 8) b[idx] = txd;
                        else stop_bit = txd;
                    end
                end
                if (!aborted) begin
                    check("stop_bit", {31'b0, stop_bit}, 32'h1);
                    check("frame_expected", {31'b0, exp_q.size() > 0}, 32'h1);
                    if (exp_q.size() > 0) begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("uart_byte", {24'h0, b}, {24'h0, e});
                    end
                end
            end
            prev = txd;
        end
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: run exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w, w10, f1, base, lows;

        // Reset state.
        reset = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        code = SYS_PUTFLOAT;
        #1;
        check("reset_txd", {31'b0, txd}, 32'h1);
        check("reset_tohost", {24'h0, tohost}, 32'h0);
        check("reset_tohost_arg", tohost_arg, 32'h0);
        check("reset_exited", {31'b0, exited}, 32'h0);
        check("reset_exit_code", exit_code, 32'h0);
        check("reset_ready_putfloat", {31'b0, ready}, 32'h1);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // Single PUTCHAR: one-cycle mirror pulse and two-cycle fire-to-start latency.
        base = fall_q.size();
        exp_q.push_back(8'h41);
        send(SYS_PUTCHAR, 32'h0000_0041, 4, w);
        @(posedge clock); #1;
        check("tohost_pulse_end", {24'h0, tohost}, 32'h0);
        wait_falls(base + 1, 4 * DIV);
        if (fall_q.size() > base) check("fire_to_start_latency", fall_q[base] - fire_cyc, 2);
        drain(2 * FRAME);

        // Ten back-to-back PUTCHARs: the tenth stalls on a full FIFO until the second pop.
        base = fall_q.size();
        f1 = 0; w10 = 0;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(8'h30 + 8'(i));
            send(SYS_PUTCHAR, {24'hA5A5A5, 8'h30 + 8'(i)}, 3 * FRAME, w);
            if (i == 0) f1 = fire_cyc;
            if (i == 9) w10 = w;
        end
        check("tenth_push_stalled", {31'b0, w10 > 0}, 32'h1);
        check("tenth_fire_cycle", fire_cyc - f1, FRAME + 3);
        drain(12 * FRAME);
        check("ten_frames_seen", fall_q.size() - base, 10);
        for (int i = 0; i < 9; i++) begin
            if (fall_q.size() > base + i + 1)
                check("frame_spacing", fall_q[base+i+1] - fall_q[base+i], FRAME + 1);
        end

        // PUTFLOAT is mirrored only; the line stays idle.
        base = fall_q.size();
        send(SYS_PUTFLOAT, 32'h3FC0_0000, 4, w);
        @(posedge clock); #1;
        check("putfloat_pulse_end", {24'h0, tohost}, 32'h0);
        count_lows(3 * DIV, lows);
        check("putfloat_txd_idle", lows, 0);
        check("putfloat_no_frame", fall_q.size(), base);
        check("tohost_arg_holds", tohost_arg, 32'h3FC0_0000);

        // EXIT waits until the queued bytes have fully left the line.
        exp_q.push_back(8'h68);
        exp_q.push_back(8'h69);
        send(SYS_PUTCHAR, 32'h0000_0068, 4, w);
        send(SYS_PUTCHAR, 32'h0000_0069, 4, w);
        send(SYS_EXIT, 32'h0000_002A, 3 * FRAME, w);
        check("exit_stalled", {31'b0, w > 0}, 32'h1);
        if (fall_q.size() > 0) check("exit_after_last_stop", fire_cyc - fall_q[$], FRAME);
        check("exited_set", {31'b0, exited}, 32'h1);
        check("exit_code", exit_code, 32'h0000_002A);
        check("exit_scoreboard_empty", exp_q.size(), 0);
        @(negedge clock);
        valid = 1'b1; code = SYS_PUTCHAR; arg = 32'h0000_0021;
        #1;
        check("putchar_after_exit_ready", {31'b0, ready}, 32'h0);
        code = SYS_PUTFLOAT;
        #1;
        check("putfloat_after_exit_ready", {31'b0, ready}, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        valid = 1'b0;
        check("exited_sticky", {31'b0, exited}, 32'h1);

        // Reset mid-DATA with three bytes queued aborts and flushes everything.
        @(negedge clock); reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        #1;
        check("reset_clears_exited", {31'b0, exited}, 32'h0);
        base = fall_q.size();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hC0 + 8'(i));
            send(SYS_PUTCHAR, {24'h0, 8'hC0 + 8'(i)}, 4, w);
        end
        wait_falls(base + 1, 4 * DIV);
        repeat (4 * DIV) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        check("txd_high_after_reset", {31'b0, txd}, 32'h1);
        exp_q.delete();
        @(negedge clock); reset = 1'b1;
        valid = 1'b0; code = SYS_EXIT;
        #1;
        check("fifo_empty_after_reset", {31'b0, ready}, 32'h1);
        base = fall_q.size();
        count_lows(12 * DIV, lows);
        check("no_frames_after_reset", fall_q.size(), base);
        check("txd_idle_after_reset", lows, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
